// File: rtl/seg7_scan_driver.sv
// Two-digit common-anode 7-segment scan driver. Re-times a slow BCD count into
// the system clock, then multiplexes ones/tens with decode and leading-zero blanking.
module seg7_scan_driver #(
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [7:0] count,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic [7:0] value_q
);
    localparam int         DIV_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [7:0]       r_s1, r_s2, r_s3;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_slot;

    logic [3:0] w_digit;
    logic       w_blank;
    logic [6:0] w_seg_hi;
    logic [1:0] w_an_hi;

    always_comb begin
        w_digit  = r_slot ? value_q[7:4] : value_q[3:0];
        w_blank  = (BLANK_LEADING != 0) && r_slot && (value_q[7:4] == 4'd0);
        w_seg_hi = 7'h40;  // dash marks a non-BCD digit
        case (w_digit)
            4'd0: w_seg_hi = 7'h3F;
            4'd1: w_seg_hi = 7'h06;
            4'd2: w_seg_hi = 7'h5B;
            4'd3: w_seg_hi = 7'h4F;
            4'd4: w_seg_hi = 7'h66;
            4'd5: w_seg_hi = 7'h6D;
            4'd6: w_seg_hi = 7'h7D;
            4'd7: w_seg_hi = 7'h07;
            4'd8: w_seg_hi = 7'h7F;
            4'd9: w_seg_hi = 7'h6F;
            default: w_seg_hi = 7'h40;
        endcase
        w_an_hi = r_slot ? 2'b10 : 2'b01;
        if (w_blank) begin
            w_seg_hi = 7'h00;
            w_an_hi  = 2'b00;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_s1      <= 8'h00;
            r_s2      <= 8'h00;
            r_s3      <= 8'h00;
            value_q   <= 8'h00;
            r_div_cnt <= '0;
            r_slot    <= 1'b0;
            seg       <= SEG_OFF;
            an        <= AN_OFF;
            dp        <= DP_OFF;
        end else begin
            r_s1 <= count;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            // accept only after two matching synchronized samples
            if (r_s2 == r_s3)
                value_q <= r_s2;
            if (r_div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
                r_div_cnt <= '0;
                r_slot    <= ~r_slot;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            seg <= w_seg_hi ^ SEG_OFF;
            an  <= w_an_hi ^ AN_OFF;
            dp  <= DP_OFF;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a history-based reference model pushes
// the expected outputs of every edge; a monitor pops and compares after the edge.
module tb_seg7_scan_driver;
    localparam int DIV = 4;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic [7:0] count      = 8'h00;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
    logic [7:0] value_q;

    seg7_scan_driver #(
        .REFRESH_DIV(DIV), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .count(count),
        .seg(seg), .dp(dp), .an(an), .value_q(value_q)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [1:0] an;
        logic [7:0] vq;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] segtab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Reference model: t = non-reset edges since reset; samp[t] = count seen at edge t.
    // value_q after edge t takes samp[t-2] when it equals samp[t-3] (earlier samples read as 0).
    // Displayed slot for edge t is (t/DIV)%2, using value_q as it stood before the edge.
    logic [7:0] samp[$];
    int         t = 0;
    logic [7:0] mvq = 8'h00;

    always @(posedge clk_100MHz) begin
        exp_t       e;
        int         slot;
        logic [3:0] d;
        logic [7:0] a, b;
        if (reset) begin
            samp.delete();
            t   = 0;
            mvq = 8'h00;
            e   = '{seg: 7'h7F, dp: 1'b1, an: 2'b11, vq: 8'h00};
        end else begin
            slot = (t / DIV) % 2;
            d    = (slot == 1) ? mvq[7:4] : mvq[3:0];
            if (slot == 1 && mvq[7:4] == 4'd0) begin
                e.seg = 7'h7F;
                e.an  = 2'b11;
            end else begin
                e.seg = ~segtab[d];
                e.an  = (slot == 1) ? 2'b01 : 2'b10;
            end
            e.dp = 1'b1;
            samp.push_back(count);
            a = (t >= 2) ? samp[t-2] : 8'h00;
            b = (t >= 3) ? samp[t-3] : 8'h00;
            if (a == b) mvq = a;
            e.vq = mvq;
            t++;
        end
        expq.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk_100MHz) begin
        exp_t e;
        #1;
        if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = expq.pop_front();
            chk("seg",     32'(seg),     32'(e.seg));
            chk("an",      32'(an),      32'(e.an));
            chk("dp",      32'(dp),      32'(e.dp));
            chk("value_q", 32'(value_q), 32'(e.vq));
            n_checks++;
            if (an === 2'b00) begin
                n_fail++;
                $display("FAIL an_overlap at %0t: got %b expected one anode at most", $time, an);
            end
        end
    end

    task automatic step(input logic [7:0] c, input int n);
        count = c;
        repeat (n) @(negedge clk_100MHz);
    endtask

    initial begin
        logic [7:0] c;
        int         guard;
        reset = 1'b1;
        count = 8'h59;
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;
        step(8'h59, 6);
        step(8'h00, 20);
        step(8'h47, 20);
        step(8'hA3, 20);
        step(8'h12, 12);
        step(8'h99, 1);
        step(8'h12, 12);
        step(8'h47, 10);
        guard = 0;
        while (((t / DIV) % 2) != 1 && guard < 4 * DIV) begin
            @(negedge clk_100MHz);
            guard++;
        end
        reset = 1'b1;
        @(negedge clk_100MHz);
        reset = 1'b0;
        step(8'h47, 12);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0)
                c = 8'($urandom);
            else
                c = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            step(c, $urandom_range(1, 6));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                @(negedge clk_100MHz);
                reset = 1'b0;
            end
        end
        repeat (2) @(negedge clk_100MHz);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

- Downstream stage of the two-digit BCD counter.
- Takes the counter's packed BCD value (tens in [7:4], ones in [3:0]) from the slow 1 Hz domain and re-times it into the fast system clock domain.
- Drives a two-digit, common-anode, time-multiplexed seven-segment display: prescaled digit scan, BCD-to-segment decode, leading-zero blanking and invalid-digit flagging.

## Interface

Parameters:
- REFRESH_DIV, 100000: clk_100MHz cycles per digit slot (1 kHz per slot at 100 MHz); legal range ≥ 2.
- BLANK_LEADING, 1: 1 = tens digit blanked when it is 0.
- SEG_ACTIVE_LOW, 1: 1 = seg/dp driven low to light a segment.
- AN_ACTIVE_LOW, 1: 1 = an driven low to enable a digit.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_100MHz  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the clk_100MHz rising edge.
- count  in  8  packed BCD from the counter, asynchronous to clk_100MHz.
- seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}.
- dp  out  1  decimal point; always held inactive.
- an  out  2  digit enables: an[0] = ones, an[1] = tens.
- value_q  out  8  currently displayed (accepted) BCD value.

## Operation

- **Input capture:**
  - count passes through two flops, s1 then s2, then a third flop s3.
  - value_q loads s2 only when s2 == s3 (two consecutive equal synchronized samples).
  - Otherwise value_q holds. A count change lasting one clock never reaches value_q.
- **Prescaler:**
  - div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the cycle div_cnt == REFRESH_DIV-1, slot toggles.
- **Slot 0 (ones):** digit = value_q[3:0]; an[0] active, an[1] inactive.
- **Slot 1 (tens):** digit = value_q[7:4]; an[1] active, an[0] inactive.
- **Tens blanking:** if BLANK_LEADING = 1 and value_q[7:4] == 0 during slot 1, then both anodes are inactive and seg is all-inactive.
- **Decode, active-high gfedcba:**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D
  - 6=7D, 7=07, 8=7F, 9=6F
  - 10..15 → 40 (dash only), flagging an invalid BCD digit.
- **Polarity:** SEG_ACTIVE_LOW inverts seg and dp. AN_ACTIVE_LOW inverts an.
- **Registered outputs:** seg, an and dp are registered. They are computed from the current slot and value_q and updated every cycle.
- **Reset values:**
  - s1 = s2 = s3 = 8'h00; value_q = 8'h00
  - div_cnt = 0; slot = 0
  - seg all-inactive (7'h7F with active-low); an both inactive (2'b11 with active-low); dp inactive (1).
- **Reset mid-scan:** asserting reset at any point returns all of the above on the next edge. The first active slot after release is slot 0.

## Timing

- **Capture latency:** count stable before edge k → s1 at k, s2 at k+1, s3 at k+2 → value_q updates at edge k+3.
- **Output latency:** seg/an reflect a new value_q or a slot change on the following edge (1 cycle).
- **Scan period:**
  - After reset release, slot 0 is held REFRESH_DIV cycles, then slot 1 for REFRESH_DIV cycles, repeating.
  - The an pattern changes exactly one cycle after each div_cnt wrap.
- **First output after reset:** the first edge with reset low drives slot 0 outputs.
- **Simultaneous events:** a value_q update and a slot toggle on the same edge are both honoured. The next output reflects the new slot with the new value.
- **No dead time:** only one anode is ever active; an never shows both active.

## Test plan

All scenarios use REFRESH_DIV=4 and default polarities.

1. **Reset:** hold reset 3 cycles with count=8'h59 → seg=7'h7F, an=2'b11, dp=1, value_q=8'h00. Release → next edge an=2'b10, seg=7'h40 (digit 0).
2. **Blanked tens:** count=8'h00 held → slot 0: an=2'b10, seg=7'h40. Slot 1: an=2'b11, seg=7'h7F. Each slot lasts exactly 4 cycles, repeating.
3. **Normal value:** count changes 8'h00→8'h47 → value_q=8'h47 at the 4th edge after the change. Slot 0: an=2'b10, seg=7'h78. Slot 1: an=2'b01, seg=7'h19.
4. **Invalid digit:** count=8'hA3 → slot 1 seg=7'h3F (dash), an=2'b01. Slot 0 seg=7'h30 (digit 3).
5. **Glitch rejection:** count at 8'h12 changes to 8'h99 for one cycle, then returns to 8'h12 → value_q stays 8'h12 throughout; seg never shows 9.
6. **Reset mid-scan:** assert reset during slot 1 with value_q=8'h47 → next edge value_q=8'h00, an=2'b11. After release, slot 0 is held for a full 4 cycles.
